// File: rtl/boot_ram_loader.sv
// Boot RAM: filled from a byte-stream loader after reset, then handed to the CPU core.
// Optional BOOT_RAM_LOADER_CHECKSUM_EN: the ld_last byte is a checksum that must zero the byte sum.
module boot_ram_loader #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_run,
  output logic [AW:0]   load_count,
  output logic [1:0]    state,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] FULL    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
  logic [DW-1:0] acc_q, acc_d, sum;
`endif

  // Handshake: a loader byte moves on a rising edge when ld_valid && ld_ready; ld_ready is a
  // pure decode of the registered state, so it never depends on ld_valid in the same cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = cpu_addr;
    mem_wdata = cpu_data;
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
    acc_d     = acc_q;
    sum       = acc_q + ld_data;
`endif
    case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
          if (ld_last) begin
            state_d = (sum == '0) ? ST_RUN : ST_ERR;
          end else if (count_q == FULL) begin
            // RAM already full; only the checksum byte is acceptable now
            state_d = ST_ERR;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = ld_data;
            ptr_d     = ptr_q + PTR_ONE;
            count_d   = count_q + CNT_ONE;
            acc_d     = sum;
          end
`else
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = ld_data;
          ptr_d     = ptr_q + PTR_ONE;
          count_d   = count_q + CNT_ONE;
          if (ld_last || count_d == FULL) state_d = ST_RUN;
`endif
        end
      end
      ST_RUN:  mem_we = cpu_we;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      count_q <= '0;
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // RAM contents survive reset; reset only blocks writes in its own cycle.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign cpu_rdata  = mem[cpu_addr];
  assign ld_ready   = (state_q == ST_LOAD);
  assign cpu_run    = (state_q == ST_RUN);
  assign load_count = count_q;
  assign state      = state_q;
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
  assign err        = (state_q == ST_ERR);
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_boot_ram_loader.sv
// Self-checking bench for boot_ram_loader: directed load sequences plus a RUN-phase vector table.
module tb_boot_ram_loader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_we;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_run;
  logic [AW:0]   load_count;
  logic [1:0]    state;
  logic          err;

  always #5 clk = ~clk;

  boot_ram_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_run(cpu_run), .load_count(load_count), .state(state), .err(err)
  );

  int            tests_run  = 0;
  int            fail_count = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] bsum;
  logic [DW-1:0] last_byte;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ldv;
    logic [DW-1:0] ldd;
    logic          chk;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b0;
    cpu_we = 1'b1; cpu_addr = 8'h01; cpu_data = 8'hEE;
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b0; cpu_we = 1'b0; bsum = '0;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = d; ld_last = last; cpu_we = 1'b0;
    if (!last) bsum = bsum + d;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; cpu_we = 1'b0;
    #1;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    logic [DW-1:0] want;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; cpu_we = 1'b0; cpu_addr = a;
    exp_q.push_back(e);
    #1;
    want = exp_q.pop_front();
    check(name, cpu_rdata, want);
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0; bsum = '0;

    vecs[0] = '{1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33};
    vecs[1] = '{1'b1, 8'h01, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h22};
    vecs[2] = '{1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A};
    vecs[3] = '{1'b1, 8'h05, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[5] = '{1'b1, 8'h04, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 8'h04, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h3C};
    vecs[7] = '{1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C};

    // Reset state
    do_reset();
    check("rst_state", state, 0);
    check("rst_count", load_count, 0);
    check("rst_run", cpu_run, 0);
    check("rst_err", err, 0);
    check("rst_ready", ld_ready, 1);

    // Basic load of four bytes
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
    send(8'h44, 1'b0);
    last_byte = 8'h00 - bsum;
`else
    last_byte = 8'h44;
`endif
    @(negedge clk);
    ld_valid = 1'b1; ld_data = last_byte; ld_last = 1'b1;
    #1;
    check("last_cycle_run", cpu_run, 0);
    check("last_cycle_ready", ld_ready, 1);
    @(posedge clk);
    read_check("first_read_a2", 8'h02, 8'h33);
    check("load_run", cpu_run, 1);
    check("load_count4", load_count, 4);
    check("load_state", state, 1);
    check("load_ready", ld_ready, 0);

    // RUN-phase vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_data = vecs[i].wdata;
      ld_valid = vecs[i].ldv; ld_data = vecs[i].ldd; ld_last = 1'b0;
      #1;
      if (vecs[i].chk) begin
        exp_q.push_back(vecs[i].exp_rd);
        check($sformatf("run_vec%0d_rdata", i), cpu_rdata, exp_q.pop_front());
      end
      if (vecs[i].ldv) check($sformatf("run_vec%0d_ready", i), ld_ready, 0);
    end
    idle();
    check("run_count_kept", load_count, 4);
    check("run_state_kept", state, 1);

    // LOAD ignores cpu_we; idle loader with stray ld_last does nothing
    do_reset();
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 8'h00; cpu_data = 8'h77; ld_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_we = 1'b0; ld_valid = 1'b0; ld_last = 1'b1;
    end
    idle();
    check("idle_state", state, 0);
    check("idle_count", load_count, 0);
    check("idle_ready", ld_ready, 1);
    read_check("load_we_ignored", 8'h00, 8'h11);

    // Reset mid-load keeps old bytes beyond the new image
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    idle();
    check("partial_count", load_count, 3);
    do_reset();
    check("midrst_count", load_count, 0);
    check("midrst_state", state, 0);
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
    send(8'h01, 1'b0);
    send(8'h00 - bsum, 1'b1);
`else
    send(8'h01, 1'b1);
`endif
    idle();
    check("reload_count", load_count, 1);
    check("reload_state", state, 1);
    read_check("reload_m0", 8'h00, 8'h01);
    read_check("reload_m1", 8'h01, 8'hA2);
    read_check("reload_m2", 8'h02, 8'hA3);

    // Full 256-byte stream without ld_last
    do_reset();
    for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
    idle();
    check("full_m1_count", load_count, 255);
    check("full_m1_state", state, 0);
    check("full_m1_ready", ld_ready, 1);
    send(8'hFF, 1'b0);
    idle();
    check("full_count", load_count, 256);
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
    check("full_wait_state", state, 0);
    check("full_wait_ready", ld_ready, 1);
    send(8'h5A, 1'b0);
    idle();
    check("overflow_state", state, 2);
    check("overflow_err", err, 1);
    check("overflow_run", cpu_run, 0);
    check("overflow_ready", ld_ready, 0);
    check("overflow_count", load_count, 256);
`else
    check("full_state", state, 1);
    check("full_ready", ld_ready, 0);
    check("full_err", err, 0);
`endif
    read_check("full_mff", 8'hFF, 8'hFF);
    read_check("full_m80", 8'h80, 8'h80);

`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
    // Checksum pass and fail
    do_reset();
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'hD0, 1'b1);
    idle();
    check("cks_ok_state", state, 1);
    check("cks_ok_count", load_count, 2);
    check("cks_ok_err", err, 0);
    read_check("cks_ok_m1", 8'h01, 8'h20);
    do_reset();
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'hD1, 1'b1);
    idle();
    check("cks_bad_state", state, 2);
    check("cks_bad_err", err, 1);
    check("cks_bad_run", cpu_run, 0);
    check("cks_bad_ready", ld_ready, 0);
    send(8'h55, 1'b1);
    idle(); idle();
    check("cks_hold_state", state, 2);
    check("cks_hold_count", load_count, 2);
    do_reset();
    check("cks_rst_state", state, 0);
    check("cks_rst_err", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/boot_ram_loader.md
Name: boot_ram_loader

Overview:
- Program/data RAM that sits directly downstream of the 8-bit microprocessor's memory port.
- Consumes the core's ram_addr, ram_data and ram_we, and produces its ram_out.
- After reset, an FSM first fills the RAM from a byte-stream loader interface using a valid/ready handshake.
- It then asserts cpu_run so the core starts executing against the loaded image.

Parameters:
- AW, 8: address width; RAM depth is 2**AW words.
- DW, 8: data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ld_valid  input  1  loader byte valid.
- ld_data  input  DW  loader byte.
- ld_last  input  1  marks final byte of the image; qualified by ld_valid.
- ld_ready  output  1  block accepts a loader byte this cycle.
- cpu_addr  input  AW  core memory address (core ram_addr).
- cpu_data  input  DW  core write data (core ram_data).
- cpu_we  input  1  core write enable (core ram_we).
- cpu_rdata  output  DW  read data to core (core ram_out).
- cpu_run  output  1  image loaded; core may execute.
- load_count  output  AW+1  number of bytes written by the loader.
- state  output  2  FSM state: LOAD=0, RUN=1, ERR=2; 3 unused.
- err  output  1  load error flag.

Behaviour:
- Reset, synchronous on clk when rst=1:
  - state=LOAD, load_count=0, internal write pointer=0, checksum accumulator=0.
  - cpu_run=0, err=0.
  - RAM contents are not cleared.
  - rst dominates every other input in the same cycle.
- Handshake: a transfer occurs on a rising edge with ld_valid && ld_ready. ld_ready is a registered-state decode, not combinationally dependent on ld_valid.
- LOAD:
  - ld_ready=1, cpu_run=0.
  - On transfer: mem[ptr]<=ld_data, ptr<=ptr+1, load_count<=load_count+1.
  - If ld_last=1 on a transfer, next state=RUN. cpu_run=1 from the following cycle, so the first core access can occur one cycle after the last transfer.
  - If the transfer fills the RAM (load_count reaches 2**AW) with no ld_last, next state=RUN. The pointer wraps to 0 but is never used again.
  - cpu_we is ignored in LOAD.
  - ld_last with ld_valid=0 has no effect.
- RUN:
  - ld_ready=0, cpu_run=1.
  - ld_valid and ld_data are ignored; only rst re-enters LOAD.
  - Write: cpu_we=1 writes mem[cpu_addr]<=cpu_data on the edge.
- Read path, all states: cpu_rdata = mem[cpu_addr], combinational (asynchronous read, zero latency), because the core latches ram_out in the same cycle it drives the address.
  - A write and a read to the same address in one cycle return the old data; new data is visible after the edge.
- ERR: ld_ready=0, cpu_run=0, err=1. Held until rst. Only reachable with CHECKSUM_EN.
- Widths: load_count saturates at 2**AW, since no further transfers are accepted. All address arithmetic is modulo 2**AW.
- Reset mid-load: returns to LOAD with count 0. Partially written bytes remain in RAM and are overwritten by the new load.

Optional Feature:
- Macro: BOOT_RAM_LOADER_CHECKSUM_EN.
- Defined:
  - The byte carrying ld_last is a checksum. It is not written to RAM and not counted in load_count.
  - Accumulator sums all data bytes modulo 2**DW.
  - On the ld_last transfer: if (acc + ld_data) mod 2**DW == 0, next state=RUN; otherwise next state=ERR.
  - After 2**AW data bytes the FSM stays in LOAD with ld_ready=1, waiting for the checksum. A further transfer with ld_last=0 goes to ERR.
- Undefined:
  - No accumulator logic.
  - ld_last bytes are ordinary data.
  - Full RAM goes straight to RUN.
  - err is tied to 0; ERR is unreachable.

Test Plan:
- Load 0x11,0x22,0x33,0x44 (last on 0x44) -> load_count=4, cpu_run=1 one cycle later; cpu_addr=2 -> cpu_rdata=0x33 in the same cycle.
- In RUN, cpu_we=1, addr=0x05, data=0xA5, then read addr 0x05 -> 0xA5. In the same RUN, ld_valid=1 with 0xFF -> RAM unchanged, ld_ready=0.
- In LOAD, cpu_we=1 at addr 0 with 0x77 -> mem[0] unchanged. Hold ld_valid=0 for 10 cycles -> state stays LOAD, count unchanged.
- Stream 256 bytes (value = index), no last -> load_count=256, RUN; addr 0xFF reads 0xFF. With checksum enabled, send 256 bytes then a non-last byte -> ERR, err=1.
- Load 3 bytes, assert rst for 1 cycle, load 0x01 with last -> load_count=1, mem[0]=0x01, mem[1..2] retain first-load data.
- CHECKSUM_EN: data 0x10,0x20 then last=0xD0 -> RUN, load_count=2. Repeat with last=0xD1 -> ERR, cpu_run=0, ld_ready=0 until rst.
